// File: rtl/sha_padder.sv
// SHA-2 message padder: packs a 64-bit byte stream into 512-bit beats and appends
// the 0x80 marker, zero fill and big-endian bit length for 512- or 1024-bit blocks.
module sha_padder #(
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int C_M_AXIS_DATA_WIDTH = 512,
  parameter int C_AXIS_TUSER_WIDTH  = 128,
  parameter int CODEC_POS           = 0
) (
  input  logic                             axis_aclk,
  input  logic                             axis_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [2:0]                       dbg_state,
  output logic [1:0]                       dbg_block_type
);

  // Handshake: a beat moves on a channel only on a clock edge where valid and
  // ready are both 1; the output side holds data/user/last stable while valid
  // is 1 and ready is 0. The two channels are never ready/valid together.

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FILL      = 3'd1;
  localparam logic [2:0] ST_EMIT_DATA = 3'd2;
  localparam logic [2:0] ST_EMIT_PAD  = 3'd3;
  localparam logic [2:0] ST_EMIT_LAST = 3'd4;

  localparam logic [15:0] CODEC_SHA224 = 16'h1013;
  localparam logic [15:0] CODEC_SHA256 = 16'h0012;
  localparam logic [15:0] CODEC_SHA384 = 16'h0020;
  localparam logic [15:0] CODEC_SHA512 = 16'h0013;

  logic [2:0]                      state_q, state_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0]  buf_q, buf_d;
  logic [2:0]                      w_q, w_d;
  logic [60:0]                     cnt_q, cnt_d;
  logic                            half_q, half_d;
  logic                            marker_done_q, marker_done_d;
  logic [C_AXIS_TUSER_WIDTH-1:0]   tuser_q, tuser_d;
  logic [1:0]                      btype_q, btype_d;
  logic                            s_tready_q, s_tready_d;
  logic                            m_tvalid_q, m_tvalid_d;
  logic                            m_tlast_q, m_tlast_d;

  logic [15:0]                     codec_raw, codec_dec;
  logic [1:0]                      btype_new;
  logic                            in_fire, out_fire;
  logic                            first_beat;
  logic [C_M_AXIS_DATA_WIDTH-1:0]  buf_n;
  logic [2:0]                      base_w;
  logic [60:0]                     base_cnt, cnt_n;
  logic                            base_half, half_n, wide;
  logic [63:0]                     word;
  logic [3:0]                      nbytes;
  logic [6:0]                      pos;
  logic                            hosts;

  function automatic logic [3:0] popcnt(input logic [7:0] k);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, k[i]};
    return c;
  endfunction

  // Length always fits in the low 64 bits; in 1024 mode bits [127:64] are
  // already zero fill, which gives the zero-extended 128-bit field.
  function automatic logic [511:0] put_len(input logic [511:0] b, input logic [60:0] c);
    logic [511:0] r;
    r = b;
    r[63:0] = {c, 3'b000};
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    w_d           = w_q;
    cnt_d         = cnt_q;
    half_d        = half_q;
    marker_done_d = marker_done_q;
    tuser_d       = tuser_q;
    btype_d       = btype_q;

    codec_raw = s_axis_tuser[CODEC_POS +: 16];
    codec_dec = codec_raw[7] ? {codec_raw[7:0], codec_raw[15:8]} : codec_raw;
    case (codec_dec)
      CODEC_SHA224: btype_new = 2'b00;
      CODEC_SHA256: btype_new = 2'b01;
      CODEC_SHA384: btype_new = 2'b10;
      CODEC_SHA512: btype_new = 2'b11;
      default:      btype_new = 2'b00;
    endcase

    in_fire    = s_axis_tvalid && s_tready_q;
    out_fire   = m_tvalid_q && m_axis_tready;
    first_beat = (state_q == ST_IDLE);
    base_w     = first_beat ? 3'd0 : w_q;
    base_cnt   = first_beat ? 61'd0 : cnt_q;
    base_half  = first_beat ? 1'b0 : half_q;
    wide       = first_beat ? btype_new[1] : btype_q[1];
    nbytes     = popcnt(s_axis_tkeep);
    cnt_n      = base_cnt + {57'd0, nbytes};
    pos        = {1'b0, base_w, 3'b000} + {3'b000, nbytes};
    half_n     = ~half_q;
    hosts      = 1'b0;
    buf_n      = first_beat ? '0 : buf_q;

    for (int i = 0; i < 8; i++)
      word[8*i +: 8] = s_axis_tkeep[i] ? s_axis_tdata[8*i +: 8] : 8'h00;

    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (in_fire) begin
          if (first_beat) begin
            tuser_d = s_axis_tuser;
            btype_d = btype_new;
          end
          buf_n[511 - 64*int'(base_w) -: 64] = word;
          cnt_d  = cnt_n;
          half_d = base_half;
          w_d    = base_w + 3'd1;
          if (!s_axis_tlast) begin
            marker_done_d = 1'b0;
            state_d = (base_w == 3'd7) ? ST_EMIT_DATA : ST_FILL;
          end else begin
            // A full 8th word leaves no room; the marker opens the next beat.
            if (pos < 7'd64) begin
              buf_n[511 - 8*int'(pos) -: 8] = 8'h80;
              marker_done_d = 1'b1;
            end else begin
              marker_done_d = 1'b0;
            end
            hosts = wide ? (base_half && (pos <= 7'd47)) : (pos <= 7'd55);
            if (hosts) begin
              buf_n   = put_len(buf_n, cnt_n);
              state_d = ST_EMIT_LAST;
            end else begin
              state_d = ST_EMIT_PAD;
            end
          end
          buf_d = buf_n;
        end
      end
      ST_EMIT_DATA: begin
        if (out_fire) begin
          buf_d = '0;
          w_d   = 3'd0;
          if (btype_q[1]) half_d = half_n;
          state_d = ST_FILL;
        end
      end
      ST_EMIT_PAD: begin
        if (out_fire) begin
          buf_n = '0;
          if (!marker_done_q) begin
            buf_n[511:504] = 8'h80;
            marker_done_d  = 1'b1;
          end
          half_d = half_n;
          hosts  = !btype_q[1] || half_n;
          if (hosts) begin
            buf_n   = put_len(buf_n, cnt_q);
            state_d = ST_EMIT_LAST;
          end else begin
            state_d = ST_EMIT_PAD;
          end
          buf_d = buf_n;
        end
      end
      ST_EMIT_LAST: begin
        if (out_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered handshake outputs follow the next state so that they read 0
    // straight out of reset and ready rises one edge later.
    s_tready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
    m_tvalid_d = (state_d == ST_EMIT_DATA) || (state_d == ST_EMIT_PAD) ||
                 (state_d == ST_EMIT_LAST);
    m_tlast_d  = (state_d == ST_EMIT_LAST);
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state_q       <= ST_IDLE;
      buf_q         <= '0;
      w_q           <= 3'd0;
      cnt_q         <= 61'd0;
      half_q        <= 1'b0;
      marker_done_q <= 1'b0;
      tuser_q       <= '0;
      btype_q       <= 2'b00;
      s_tready_q    <= 1'b0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      w_q           <= w_d;
      cnt_q         <= cnt_d;
      half_q        <= half_d;
      marker_done_q <= marker_done_d;
      tuser_q       <= tuser_d;
      btype_q       <= btype_d;
      s_tready_q    <= s_tready_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
    end
  end

  assign s_axis_tready  = s_tready_q;
  assign m_axis_tvalid  = m_tvalid_q;
  assign m_axis_tlast   = m_tlast_q;
  assign m_axis_tdata   = buf_q;
  assign m_axis_tuser   = tuser_q;
  assign dbg_state      = state_q;
  assign dbg_block_type = btype_q;

endmodule

// File: tb/tb_sha_padder.sv
// Bench for sha_padder: random and directed messages, checked against a
// byte-level padding model, plus backpressure and mid-message reset.
module tb_sha_padder;

  logic         clk = 1'b0;
  logic         axis_resetn;
  logic [63:0]  s_axis_tdata;
  logic [7:0]   s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [511:0] m_axis_tdata;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [2:0]   dbg_state;
  logic [1:0]   dbg_block_type;

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;  // 0 random, 1 held low, 2 held high

  logic [512:0] exp_q[$];
  logic [127:0] exp_user_q[$];
  logic [7:0]   msg_q[$];
  logic [512:0] mon_e;
  logic [127:0] mon_u;

  sha_padder dut (
    .axis_aclk      (clk),
    .axis_resetn    (axis_resetn),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .dbg_state      (dbg_state),
    .dbg_block_type (dbg_block_type)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_wide(input logic [15:0] raw);
    logic [15:0] d;
    d = (raw[7:0] >= 8'h80) ? {raw[7:0], raw[15:8]} : raw;
    return (d == 16'h0013) || (d == 16'h0020);
  endfunction

  // Reference: lay out the whole padded message as bytes, then cut 64-byte beats.
  task automatic model(input logic [127:0] user);
    int L, blk, lb, tot;
    logic [7:0]   pad[];
    logic [63:0]  bits;
    logic [511:0] beat;
    L   = msg_q.size();
    blk = is_wide(user[15:0]) ? 128 : 64;
    lb  = is_wide(user[15:0]) ? 16 : 8;
    tot = ((L + 1 + lb + blk - 1) / blk) * blk;
    pad = new[tot];
    foreach (pad[i]) pad[i] = 8'h00;
    for (int i = 0; i < L; i++) pad[i] = msg_q[i];
    pad[L] = 8'h80;
    bits = 64'(L) * 64'd8;
    for (int i = 0; i < 8; i++) pad[tot-1-i] = bits[8*i +: 8];
    for (int b = 0; b < tot / 64; b++) begin
      for (int j = 0; j < 64; j++) beat[511 - 8*j -: 8] = pad[b*64 + j];
      exp_q.push_back({(b == tot/64 - 1) ? 1'b1 : 1'b0, beat});
      exp_user_q.push_back(user);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic [127:0] u);
    int guard;
    guard = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!s_axis_tready) check("in_ready_timeout", 512'd0, 512'd1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_msg(input logic [127:0] user);
    int L, nb, idx;
    logic [63:0] d;
    logic [7:0]  k;
    L  = msg_q.size();
    nb = (L == 0) ? 1 : (L + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      d = {$urandom, $urandom};
      k = 8'h00;
      for (int j = 0; j < 8; j++) begin
        idx = b*8 + j;
        if (idx < L) begin
          d[63 - 8*j -: 8] = msg_q[idx];
          k[7 - j] = 1'b1;
        end
      end
      drive_beat(d, k, (b == nb - 1), (b == 0) ? user : {$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || m_axis_tvalid) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0 || m_axis_tvalid) check("drain_timeout", 512'd0, 512'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic mk_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  function automatic logic [127:0] mk_user(input logic [15:0] codec);
    logic [127:0] u;
    u = {$urandom, $urandom, $urandom, $urandom};
    u[15:0] = codec;
    return u;
  endfunction

  task automatic run_msg(input int len, input logic [15:0] codec);
    logic [127:0] u;
    mk_msg(len);
    u = mk_user(codec);
    model(u);
    send_msg(u);
    wait_drain();
  endtask

  task automatic run_abc256();
    logic [127:0] u;
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    u = mk_user(16'h0012);
    exp_q.push_back({1'b1, 32'h61626380, 416'd0, 64'h18});
    exp_user_q.push_back(u);
    send_msg(u);
    wait_drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_tready"}, 512'(s_axis_tready), 512'd0);
    check({tag, "_m_tvalid"}, 512'(m_axis_tvalid), 512'd0);
    check({tag, "_m_tlast"},  512'(m_axis_tlast),  512'd0);
    check({tag, "_m_tdata"},  m_axis_tdata,        512'd0);
    check({tag, "_m_tuser"},  512'(m_axis_tuser),  512'd0);
  endtask

  // Output monitor: at the negedge, a beat with valid and ready will be taken
  // on the coming edge.
  always @(negedge clk) begin
    if (axis_resetn && m_axis_tvalid && m_axis_tready) begin
      check("exclusive_ready", 512'(s_axis_tready), 512'd0);
      if (exp_q.size() == 0) begin
        check("extra_beat", 512'd1, 512'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_u = exp_user_q.pop_front();
        check("tdata", m_axis_tdata, mon_e[511:0]);
        check("tlast", 512'(m_axis_tlast), 512'(mon_e[512]));
        check("tuser", 512'(m_axis_tuser), 512'(mon_u));
      end
    end
  end

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = ($urandom_range(0, 3) != 0);
        1:       m_axis_tready = 1'b0;
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

  initial begin
    logic [511:0] stall_exp;
    int guard;
    logic [127:0] u;
    axis_resetn   = 1'b0;
    s_axis_tdata  = 64'd0;
    s_axis_tkeep  = 8'd0;
    s_axis_tuser  = 128'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    axis_resetn = 1'b1;
    @(negedge clk);
    check("tready_before_edge", 512'(s_axis_tready), 512'd0);
    @(negedge clk);
    check("tready_after_edge", 512'(s_axis_tready), 512'd1);
    @(posedge clk);
    #1;

    // Directed cases: sizes around the marker and length-field boundaries.
    run_abc256();
    run_msg(0,   16'h0012);
    run_msg(56,  16'h0012);
    run_msg(64,  16'h0012);
    run_msg(55,  16'h0012);
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    u = mk_user(16'h0013);
    exp_q.push_back({1'b0, 32'h61626380, 480'd0});
    exp_q.push_back({1'b1, 448'd0, 64'h18});
    exp_user_q.push_back(u);
    exp_user_q.push_back(u);
    send_msg(u);
    wait_drain();
    run_msg(112, 16'h0013);
    run_msg(111, 16'h0013);
    run_msg(128, 16'h0013);
    run_msg(50,  16'h0020);
    run_msg(20,  16'h1013);
    run_msg(70,  16'h7777);
    run_msg(60,  16'h1393);

    for (int i = 0; i < 25; i++) begin
      int kind;
      logic [15:0] codec;
      kind = $urandom_range(0, 3);
      codec = (kind == 0) ? 16'h0012 : (kind == 1) ? 16'h0013 :
              (kind == 2) ? 16'h0020 : 16'h1013;
      run_msg($urandom_range(0, 200), codec);
    end

    // Backpressure on a data beat, then reset with the message half done.
    rdy_mode = 1;
    mk_msg(64);
    for (int j = 0; j < 64; j++) stall_exp[511 - 8*j -: 8] = msg_q[j];
    u = mk_user(16'h0012);
    for (int b = 0; b < 8; b++)
      drive_beat({msg_q[8*b], msg_q[8*b+1], msg_q[8*b+2], msg_q[8*b+3],
                  msg_q[8*b+4], msg_q[8*b+5], msg_q[8*b+6], msg_q[8*b+7]},
                 8'hFF, 1'b0, (b == 0) ? u : 128'd0);
    guard = 0;
    @(negedge clk);
    while (!m_axis_tvalid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("stall_reach_valid", 512'(m_axis_tvalid), 512'd1);
    for (int c = 0; c < 5; c++) begin
      check("stall_tdata",    m_axis_tdata,          stall_exp);
      check("stall_tvalid",   512'(m_axis_tvalid),   512'd1);
      check("stall_s_tready", 512'(s_axis_tready),   512'd0);
      check("stall_tlast",    512'(m_axis_tlast),    512'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    axis_resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    exp_q.delete();
    exp_user_q.delete();
    @(posedge clk);
    #1;
    axis_resetn = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    run_abc256();

    check("queue_empty", 512'(exp_q.size()), 512'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/sha_padder.md
# sha_padder

Message padder for the SHA-2 pipeline. It accepts a raw byte message as a 64-bit AXI-Stream, applies FIPS 180-4 padding (0x80 marker, zero fill, big-endian bit-length field) and emits whole 512-bit beats. These beats feed `wt_unit` directly: one beat per block for SHA-224/256, and two beats per block (left half, then right half) for SHA-384/512. `tlast` marks the final beat of the message, and the message's `tuser` is forwarded unchanged.

## Interface
- `C_S_AXIS_DATA_WIDTH`, default 64: input data width. Fixed at 64; no other value is supported.
- `C_M_AXIS_DATA_WIDTH`, default 512: output data width. Fixed at 512.
- `C_AXIS_TUSER_WIDTH`, default 128: sideband width. The codec field sits at `CODEC_POS`, as defined in `multiformats_codec.vh`.
- `axis_aclk`  in  1  clock. Single clock domain.
- `axis_resetn`  in  1  reset. Synchronous, active-low.
- `s_axis_tdata`  in  64  message bytes, big-endian. The first byte is in `[63:56]`.
- `s_axis_tkeep`  in  8  byte enables. Bit 7 qualifies `[63:56]`. Must be contiguous from the MSB. Must be `8'hFF` on every beat except the `tlast` beat.
- `s_axis_tuser`  in  128  codec and slot info. Sampled on the first beat of each message only.
- `s_axis_tvalid`  in  1
- `s_axis_tready`  out  1
- `s_axis_tlast`  in  1  last beat of the message.
- `m_axis_tdata`  out  512  padded beat, big-endian. Word 0 occupies `[511:448]`.
- `m_axis_tuser`  out  128  latched `tuser` of the current message.
- `m_axis_tvalid`  out  1
- `m_axis_tready`  in  1
- `m_axis_tlast`  out  1  final beat of the message.

## Operation
- **Codec decode.** The codec is taken from `tuser[CODEC_POS+15:CODEC_POS]`. If the low byte is ≥ 0x80, the two bytes are swapped (varint).
- **Block type.** Decoded codecs map as 224→00, 256→01, 384→10, 512→11. Unknown codecs map to 00. Bit 1 selects 1024-bit blocks.
- **State registers.**
  - 512-bit buffer.
  - 3-bit word index `w`.
  - 61-bit byte counter, which wraps; messages of 2^61 bytes or more are unsupported.
  - `half` bit, used in 1024 mode only: 0 = L beat, 1 = R beat.
  - `marker_done` flag.
  - Latched `tuser` and block type.
- **IDLE.** `s_axis_tready`=1. The first accepted beat latches `tuser` and the block type, clears the counter, `half` and `marker_done`, and is processed as a FILL beat. The state moves to FILL.
- **FILL (per accepted beat).**
  - Write the beat to word `w`.
  - Add popcount(`tkeep`) to the counter.
  - Increment `w`.
- **FILL, not `tlast`.**
  - `w`=7 → EMIT_DATA.
  - Otherwise stay in FILL.
- **FILL, `tlast`.**
  - Place 0x80 at the byte following the last valid byte, and zero all later bytes of the buffer. If `tkeep`=FF and `w`=7, there is no room, so the marker is deferred (`marker_done`=0).
  - The beat "hosts length" in two cases:
    - 512 mode, with ≥8 free bytes after the marker.
    - 1024 mode with `half`=1, with ≥16 free bytes after the marker.
  - If it hosts length: write `counter×8` into the last 8 bytes (512 mode) or the last 16 bytes (1024 mode, zero-extended to 128 bits), then go to EMIT_LAST.
  - If it does not: go to EMIT_PAD.
- **EMIT_DATA.** On handshake: clear the buffer, set `w`=0, toggle `half` (1024 mode), go to FILL.
- **EMIT_PAD.** On handshake, the buffer is replaced by the next beat:
  - Start from zeros. If `marker_done`=0, place 0x80 at byte 0 and set `marker_done`=1.
  - Toggle `half`.
  - If the new beat hosts length, insert the length and go to EMIT_LAST. Otherwise stay in EMIT_PAD (1024 mode, L half).
- **EMIT_LAST.** `m_axis_tlast`=1. On handshake go to IDLE.
- **Input handshake.** `s_axis_tready`=0 in all EMIT states.
- **Output handshake.** Standard AXI-Stream: `tdata`, `tuser` and `tlast` are held stable while `tvalid`=1 and `tready`=0.

## Timing
- **Reset values.** All outputs are 0: `s_axis_tready`, `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `m_axis_tuser`. The FSM returns to IDLE.
- **Ready after reset.** `s_axis_tready` rises on the first edge after reset is released.
- **Output latency.** `m_axis_tvalid` rises on the edge after the completing input beat is accepted (the 8th word, or the `tlast` beat).
- **Return to input.** After an EMIT_DATA or EMIT_LAST handshake, `m_axis_tvalid` drops and `s_axis_tready` rises on the next edge.
- **Pad sequences.** After an EMIT_PAD handshake, the next beat is presented on the next edge with `m_axis_tvalid` held at 1, so there is no bubble.
- **Reset mid-message.** The partial message is discarded and every output takes its reset value at the next edge. The next message after reset is padded correctly.
- **Simultaneous events.** Input and output handshakes never coincide, because `s_axis_tready` and `m_axis_tvalid` are mutually exclusive.

## Test plan
- **SHA-256 "abc".** Stimulus: `tdata`=0x6162630000000000, `tkeep`=E0, `tlast`. Required: one beat 0x61626380, zeros, final 64 bits = 0x18; `tlast`=1.
- **SHA-256 empty message.** Stimulus: single beat, `tkeep`=00, `tlast`. Required: one beat with byte 0 = 0x80, the rest zero, length field 0; `tlast`=1.
- **SHA-256, 56 bytes** (7 beats with FF, `tlast` on the 7th). Required:
  - Beat 1: data, then 0x80 at byte 56, `tlast`=0.
  - Beat 2: zeros, final 64 bits = 0x1C0, `tlast`=1.
- **SHA-256, 64 bytes** (`tlast` on the 8th full beat). Required:
  - Beat 1: data, `tlast`=0.
  - Beat 2: 0x80 at byte 0, final 64 bits = 0x200, `tlast`=1.
- **SHA-512 "abc".** Required:
  - L beat: 0x61626380, then zeros, `tlast`=0.
  - R beat: zeros, final 128 bits = 0x18, `tlast`=1.
- **SHA-512, 112 bytes.** Required: 4 beats; the last carries length 0x380.
- **Backpressure and reset.** Hold `m_axis_tready` low for 5 cycles. Required: `tdata` and `tvalid` stable, `s_axis_tready`=0. Then assert reset in the middle of a message. Required: all outputs 0 at the next edge, and a following "abc" message produces the first test's result.
